// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU: operation select codes and sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SRA = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier datapath; one partial product per step, sequenced by the
// ALU controller through i_start / i_step.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic [WIDTH:0]     w_sum;

  // Carry out of the upper-half add becomes the new MSB after the right shift.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == CW'(WIDTH));
  assign o_hi   = r_acc[2*WIDTH-1:WIDTH];
  assign o_lo   = r_acc[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake, shifts and iterative unsigned multiply (HI/LO).
// Optional build macro ALU_OVERFLOW_EN adds the registered signed-overflow output oflow.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
`ifdef ALU_OVERFLOW_EN
  output logic             oflow,
`endif
  output logic             zero
);

  alu_state_e r_state, w_state_d;

  logic [WIDTH-1:0] r_result, r_hi;
  logic             r_zero;
  logic             w_accept, w_start, w_step, w_mul_done;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH-1:0] w_sum, w_diff, w_alu;
  logic [SHW-1:0]   w_shamt;
  logic             w_sub_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_shamt  = b[SHW-1:0];
  assign w_sum    = a + b;
  assign w_diff   = a - b;
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    w_alu = '0;
    case (ctl)
      ALU_AND: w_alu = a & b;
      ALU_OR:  w_alu = a | b;
      ALU_ADD: w_alu = w_sum;
      ALU_SUB: w_alu = w_diff;
      // Sign of the difference corrected for overflow gives the true signed compare.
      ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
      ALU_NOR: w_alu = ~(a | b);
      ALU_XOR: w_alu = a ^ b;
      ALU_SLL: w_alu = a << w_shamt;
      ALU_SRL: w_alu = a >> w_shamt;
      ALU_SRA: w_alu = $unsigned($signed(a) >>> w_shamt);
      default: w_alu = '0;
    endcase
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_start),
    .i_step (w_step),
    .i_a    (a),
    .i_b    (b),
    .o_done (w_mul_done),
    .o_hi   (w_mul_hi),
    .o_lo   (w_mul_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_d = (ctl == ALU_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (w_mul_done) w_state_d = DONE;
      end
      DONE: begin
        if (w_accept) begin
          w_state_d = (ctl == ALU_MUL) ? MUL : DONE;
        end else if (out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    out_valid = (r_state == DONE);
    w_start   = w_accept && (ctl == ALU_MUL);
    w_step    = (r_state == MUL) && !w_mul_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept && (ctl != ALU_MUL)) begin
      r_result <= w_alu;
      r_hi     <= '0;
      r_zero   <= (w_alu == '0);
    end else if ((r_state == MUL) && w_mul_done) begin
      r_result <= w_mul_lo;
      r_hi     <= w_mul_hi;
      r_zero   <= (w_mul_lo == '0);
    end
  end

  assign result = r_result;
  assign hi     = r_hi;
  assign zero   = r_zero;

`ifdef ALU_OVERFLOW_EN
  logic r_oflow;
  logic w_add_ovf, w_oflow;

  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_oflow   = ((ctl == ALU_ADD) && w_add_ovf) || ((ctl == ALU_SUB) && w_sub_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oflow <= 1'b0;
    end else if (w_accept && (ctl != ALU_MUL)) begin
      r_oflow <= w_oflow;
    end else if ((r_state == MUL) && w_mul_done) begin
      r_oflow <= 1'b0;
    end
  end

  assign oflow = r_oflow;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32); checks oflow when
// ALU_OVERFLOW_EN is defined.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]  ctl;
  logic [31:0] a, b, result, hi;
`ifdef ALU_OVERFLOW_EN
  logic        oflow;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  logic ready_bad;

  always #5 clk = ~clk;

  alu_multicycle #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ctl      (ctl),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .hi       (hi),
`ifdef ALU_OVERFLOW_EN
    .oflow    (oflow),
`endif
    .zero     (zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; presents a request and returns 1 time unit after its accept edge.
  task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] x,
                       input logic [31:0] y);
    in_valid = 1'b1;
    ctl = c;
    a = x;
    b = y;
    #1;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctl = 4'd15;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
  endtask

  task automatic single(input string tag, input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res);
    issue(tag, c, x, y);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_result"}, {32'd0, result}, {32'd0, exp_res});
    chk({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_res == 32'd0});
    chk({tag, "_hi"}, {32'd0, hi}, 64'd0);
  endtask

  task automatic mul_run(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(tag, 4'd8, x, y);
    a = ~x;
    b = y + 32'd7;
    ready_bad = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) ready_bad = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd33);
    chk({tag, "_no_ready"}, {63'd0, ready_bad}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, result}, {32'd0, exp_lo});
    chk({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_lo == 32'd0});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ctl = 4'd0;
    a = 32'd0;
    b = 32'd0;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    single("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
`ifdef ALU_OVERFLOW_EN
    chk("add_oflow", {63'd0, oflow}, 64'd1);
`endif
    single("slt_neg", 4'd7, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001);
    single("slt_pos", 4'd7, 32'h0000_0003, 32'hFFFF_FFFB, 32'h0000_0000);
    single("slt_ovf", 4'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    single("sub_zero", 4'd6, 32'd5, 32'd5, 32'd0);
`ifdef ALU_OVERFLOW_EN
    chk("sub_oflow", {63'd0, oflow}, 64'd0);
`endif
    single("sra", 4'd5, 32'h8000_0000, 32'd36, 32'hF800_0000);
    single("srl", 4'd4, 32'h8000_0000, 32'd36, 32'h0800_0000);
    single("sll", 4'd3, 32'h0000_0001, 32'd31, 32'h8000_0000);
    single("or", 4'd1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    single("nor", 4'd12, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
    single("xor", 4'd13, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    single("undef", 4'd9, 32'h0000_000F, 32'h0000_0003, 32'h0000_0000);

    mul_run("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul_run("mul_shift", 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);

    // Backpressure: result must hold while out_ready stays low.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    single("bp_and", 4'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_result", {32'd0, result}, 64'h0F00_0F00);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    single("bp_next_add", 4'd2, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);

    // Reset in the middle of a multiply.
    issue("rst_mul", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_zero", {63'd0, zero}, 64'd1);
    chk("midrst_result", {32'd0, result}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_ready", {63'd0, in_ready}, 64'd1);
    chk("postrst_valid", {63'd0, out_valid}, 64'd0);
    single("postrst_add", 4'd2, 32'd2, 32'd3, 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the datapath ALU. Adds WIDTH generalisation, shifts, and an iterative unsigned multiply with a HI/LO result.
- Uses a valid/ready handshake on both input and output, so it can sit in a multicycle or pipelined datapath with a stalling EX stage.
- Single-cycle ops (add/sub/logic/slt/shift) return one cycle after acceptance. mul uses a shift-add sequencer.

Parameters:
- WIDTH, 32: operand/result width; must be at least 4.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept request
- ctl  input  4  operation select (encodings below)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; shift amount is b[SHW-1:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  result (LO half for mul)
- hi  output  WIDTH  upper product half for mul; 0 for all other ops
- zero  output  1  result == 0 (LO only for mul)

Behaviour:
- ctl encodings:
  - 0 and, 1 or, 2 add, 6 sub, 7 slt, 12 nor, 13 xor
  - 3 sll, 4 srl, 5 sra
  - 8 mul (unsigned)
  - any other value: result 0, single-cycle.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - slt is signed two's complement and must be correct under subtraction overflow: result = sign(a-b) XOR overflow_sub, zero-extended.
  - Shifts use only b[SHW-1:0]; upper bits of b are ignored.
- Handshake:
  - Accept occurs on a clock edge with in_valid && in_ready.
  - a, b and ctl are captured at accept; later input changes are ignored.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue with no bubble.
- States:
  - IDLE: on accept of a single-cycle op, compute and register result/hi/zero, then go to DONE. On accept of mul, clear the accumulator, load the multiplicand/multiplier and count=0, then go to MUL.
  - MUL: each cycle, if multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH accumulator; then shift right by one and increment count. After WIDTH iterations, load hi/result from the accumulator and go to DONE.
  - DONE: out_valid=1; result/hi/zero held stable until out_ready. On out_ready: if a new request is accepted in the same cycle, process it as from IDLE; otherwise go to IDLE.
- Latency:
  - Single-cycle op: out_valid is high in the cycle after the accept edge.
  - mul: out_valid is high WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
- out_valid is 0 in IDLE and MUL.
- Reset: async assertion at any time, including mid-mul, forces:
  - state=IDLE, out_valid=0, result=0, hi=0, zero=1, count=0
  - in_ready=1 from the first edge after release.
- The consumer may hold out_ready low indefinitely; outputs must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - Adds output port oflow (1 bit), registered alongside result.
  - oflow is the signed overflow of add (ctl 2) or sub (ctl 6); 0 for all other ops.
  - oflow resets to 0.
- When undefined: the port and its logic are absent.

Decomposition:
- Package alu_pkg:
  - ctl encoding localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SUB, ALU_SLT, ALU_MUL, ALU_NOR, ALU_XOR)
  - state encoding (IDLE, MUL, DONE).
- Sub-module alu_mul_iter: shift-add multiplier datapath with start, step, count and done.
  - Parametrised by WIDTH.
  - Owns the 2*WIDTH accumulator.
  - Controlled by the top FSM.
- The single-cycle combinational op mux stays in alu_multicycle.

Test Plan (WIDTH=32):
- add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, zero=0, out_valid one cycle after accept; with ALU_OVERFLOW_EN, oflow=1.
- slt a=0x80000000, b=0x00000001 -> result 1. slt a=0x00000003, b=0xFFFFFFFB -> result 0. sub 5-5 -> result 0, zero=1.
- sra 0x80000000 by b=36 (amount 4) -> result 0xF8000000. srl of the same operand -> 0x08000000. sll 0x1 by 31 -> 0x80000000.
- mul 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, result=0x00000001, out_valid exactly 33 cycles after accept; in_ready=0 throughout MUL; operands changed mid-op do not affect the result.
- Backpressure: complete an and op, hold out_ready=0 for 3 cycles -> result stable and out_valid held; then out_ready=1 with a new add request in the same cycle -> accepted with no bubble, next result one cycle later.
- Assert rst_n=0 at mul iteration 10 -> outputs immediately reset (out_valid=0, zero=1); after release, in_ready=1, and a new add 2+3 returns 5.
